// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared types and constants for the gate sweep controller: FSM states,
// standard 2-input truth tables and counter sizing.
package gate_sweep_ctrl_pkg;

  localparam int unsigned NUM_VEC    = 4;
  localparam int unsigned VEC_W      = 2;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit i is the expected gate output for {a,b} = i.
  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;

  typedef struct packed {
    logic               pass;
    logic [NUM_VEC-1:0] fail_mask;
  } result_t;

  function automatic bit settle_legal(input int unsigned cyc);
    return (cyc >= SETTLE_MIN) && (cyc <= SETTLE_MAX);
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle.sv
// Loadable 4-bit down-counter timing how long each vector is held before
// the gate output is sampled.
module settle_counter
  import gate_sweep_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate through all four input vectors, samples its output
// after a settle period and reports per-vector mismatches.
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] TRUTH      = TT_OR,
  parameter int unsigned        SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               y,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] fail_mask,
  output logic [VEC_W-1:0]   vec_idx
);

  if (!settle_legal(SETTLE_CYC)) begin : g_bad_settle
    $error("gate_sweep_ctrl: SETTLE_CYC must be within 1..15");
  end

  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [VEC_W-1:0] LAST_VEC      = VEC_W'(NUM_VEC - 1);

  state_t             state, state_next;
  logic [VEC_W-1:0]   vec_idx_next;
  result_t            res, res_next;
  logic               busy_next;
  logic               done_next;
  logic               cnt_load;
  logic               cnt_en;
  logic               cnt_zero;

  settle_counter u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_RELOAD),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      vec_idx <= '0;
      res     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      vec_idx <= vec_idx_next;
      res     <= res_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // Next-state and next-output logic; the result is final on the edge into DONE.
  always_comb begin
    state_next   = state;
    vec_idx_next = vec_idx;
    res_next     = res;
    busy_next    = busy;
    done_next    = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_SETTLE;
          vec_idx_next = '0;
          res_next     = '0;
          busy_next    = 1'b1;
          cnt_load     = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          state_next = ST_SAMPLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (y != TRUTH[vec_idx]) begin
          res_next.fail_mask[vec_idx] = 1'b1;
        end
        if (vec_idx == LAST_VEC) begin
          state_next    = ST_DONE;
          done_next     = 1'b1;
          busy_next     = 1'b0;
          res_next.pass = (res_next.fail_mask == '0);
        end else begin
          state_next   = ST_SETTLE;
          vec_idx_next = vec_idx + VEC_W'(1);
          cnt_load     = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign a         = vec_idx[1];
  assign b         = vec_idx[0];
  assign pass      = res.pass;
  assign fail_mask = res.fail_mask;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized self-checking bench for gate_sweep_ctrl: three instances
// (OR/2-cycle, AND/2-cycle, OR/5-cycle) checked against a sweep-level model.
module tb_gate_sweep_ctrl;

  localparam logic [3:0] T_OR  = 4'b1110;
  localparam logic [3:0] T_AND = 4'b1000;

  logic clk;
  logic rst;
  logic start_m, start_5;
  logic [3:0] gt_m, gt_5;
  logic glitch_m, glitch_5, gv_m, gv_5;
  logic y_m, y_n, y_5;

  logic a_m, b_m, busy_m, done_m, pass_m;
  logic [3:0] fm_m;
  logic [1:0] vec_m;
  logic a_n, b_n, busy_n, done_n, pass_n;
  logic [3:0] fm_n;
  logic [1:0] vec_n;
  logic a_5, b_5, busy_5, done_5, pass_5;
  logic [3:0] fm_5;
  logic [1:0] vec_5;

  int errors = 0;
  int checks = 0;

  // Bench-side gate models: a lookup of the connected gate, optionally glitched.
  assign y_m = glitch_m ? gv_m : gt_m[{a_m, b_m}];
  assign y_n = gt_m[{a_n, b_n}];
  assign y_5 = glitch_5 ? gv_5 : gt_5[{a_5, b_5}];

  gate_sweep_ctrl #(.TRUTH(T_OR), .SETTLE_CYC(2)) u_dut (
    .clk(clk), .rst(rst), .start(start_m), .y(y_m), .a(a_m), .b(b_m),
    .busy(busy_m), .done(done_m), .pass(pass_m), .fail_mask(fm_m), .vec_idx(vec_m)
  );

  gate_sweep_ctrl #(.TRUTH(T_AND), .SETTLE_CYC(2)) u_and (
    .clk(clk), .rst(rst), .start(start_m), .y(y_n), .a(a_n), .b(b_n),
    .busy(busy_n), .done(done_n), .pass(pass_n), .fail_mask(fm_n), .vec_idx(vec_n)
  );

  gate_sweep_ctrl #(.TRUTH(T_OR), .SETTLE_CYC(5)) u_s5 (
    .clk(clk), .rst(rst), .start(start_5), .y(y_5), .a(a_5), .b(b_5),
    .busy(busy_5), .done(done_5), .pass(pass_5), .fail_mask(fm_5), .vec_idx(vec_5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({a_m, b_m, busy_m, done_m, pass_m, fm_m, vec_m} !== 11'd0) begin
      errors++;
      $display("FAIL reset_main: got %b exp 0", {a_m, b_m, busy_m, done_m, pass_m, fm_m, vec_m});
    end
    checks++;
    if ({a_5, b_5, busy_5, done_5, pass_5, fm_5, vec_5} !== 11'd0) begin
      errors++;
      $display("FAIL reset_s5: got %b exp 0", {a_5, b_5, busy_5, done_5, pass_5, fm_5, vec_5});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One full sweep with the connected gate's truth table gt; expectations
  // come from vector timing arithmetic and fail_mask = gt ^ TRUTH.
  task automatic run_sweep(input bit sel, input logic [3:0] gt, input bit glitch);
    int s, n;
    logic [3:0] efm;
    logic [1:0] ev, ov;
    logic oa, ob, obusy, odone, opass;
    logic [3:0] ofm;
    bit g;
    s = sel ? 5 : 2;
    n = 4 * (s + 1);
    efm = gt ^ T_OR;
    if (sel) begin gt_5 = gt; start_5 = 1'b1; end
    else begin gt_m = gt; start_m = 1'b1; end
    @(posedge clk); #1;
    start_m = 1'b0;
    start_5 = 1'b0;
    for (int j = 0; j <= n; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      ov = sel ? vec_5 : vec_m;   oa = sel ? a_5 : a_m;     ob = sel ? b_5 : b_m;
      obusy = sel ? busy_5 : busy_m; odone = sel ? done_5 : done_m;
      opass = sel ? pass_5 : pass_m; ofm = sel ? fm_5 : fm_m;
      if (j < n) begin
        ev = 2'(j / (s + 1));
        checks++;
        if (ov !== ev || {oa, ob} !== ev) begin
          errors++;
          $display("FAIL vector sel=%0d j=%0d: vec=%0d ab=%b exp %0d", sel, j, ov, {oa, ob}, ev);
        end
        checks++;
        if (obusy !== 1'b1 || odone !== 1'b0) begin
          errors++;
          $display("FAIL busy_done sel=%0d j=%0d: busy=%b done=%b exp busy=1 done=0", sel, j, obusy, odone);
        end
        if (j == 0) begin
          checks++;
          if (ofm !== 4'd0 || opass !== 1'b0) begin
            errors++;
            $display("FAIL start_clear sel=%0d: fm=%b pass=%b exp fm=0000 pass=0", sel, ofm, opass);
          end
        end
        g = glitch && ((j % (s + 1)) != s);
        if (sel) begin glitch_5 = g; gv_5 = 1'($urandom); end
        else begin glitch_m = g; gv_m = 1'($urandom); end
        if (g) begin
          #3;
          if (sel) gv_5 = 1'($urandom); else gv_m = 1'($urandom);
        end
      end else begin
        glitch_m = 1'b0;
        glitch_5 = 1'b0;
        checks++;
        if (odone !== 1'b1 || obusy !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse sel=%0d: done=%b busy=%b exp done=1 busy=0", sel, odone, obusy);
        end
        checks++;
        if (ofm !== efm || opass !== (efm == 4'd0)) begin
          errors++;
          $display("FAIL result sel=%0d gt=%b: fm=%b pass=%b exp fm=%b pass=%b", sel, gt, ofm, opass, efm, efm == 4'd0);
        end
        if (!sel) begin
          checks++;
          if (done_n !== 1'b1 || fm_n !== (gt ^ T_AND) || pass_n !== ((gt ^ T_AND) == 4'd0)) begin
            errors++;
            $display("FAIL and_result gt=%b: done=%b fm=%b pass=%b exp done=1 fm=%b", gt, done_n, fm_n, pass_n, gt ^ T_AND);
          end
        end
      end
    end
    @(posedge clk); #1;
    odone = sel ? done_5 : done_m; oa = sel ? a_5 : a_m; ob = sel ? b_5 : b_m;
    ofm = sel ? fm_5 : fm_m;
    checks++;
    if (odone !== 1'b0 || {oa, ob} !== 2'b11 || ofm !== efm) begin
      errors++;
      $display("FAIL post_sweep sel=%0d: done=%b ab=%b fm=%b exp done=0 ab=11 fm=%b", sel, odone, {oa, ob}, ofm, efm);
    end
  endtask

  task automatic test_or_and();
    run_sweep(1'b0, T_OR, 1'b0);
  endtask

  task automatic test_stuck_then_good();
    run_sweep(1'b0, 4'b0000, 1'b0);
    run_sweep(1'b0, T_OR, 1'b0);
  endtask

  task automatic test_start_ignored();
    int ndone;
    gt_m = T_OR;
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (vec_m !== 2'd2) begin
      errors++;
      $display("FAIL ignore_at_vec2: vec=%0d exp 2", vec_m);
    end
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_m) ndone++;
    end
    checks++;
    if (ndone !== 1 || busy_m !== 1'b0 || pass_m !== 1'b1) begin
      errors++;
      $display("FAIL ignore_single_done: dones=%0d busy=%b pass=%b exp 1 0 1", ndone, busy_m, pass_m);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, first, second;
    first = -1;
    second = -1;
    start_m = 1'b1;
    for (cyc = 0; cyc < 60 && second < 0; cyc++) begin
      @(posedge clk); #1;
      if (done_m) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    start_m = 1'b0;
    checks++;
    if (first < 0 || second < 0 || (second - first) != 14) begin
      errors++;
      $display("FAIL held_start_period: first=%0d second=%0d exp spacing 14", first, second);
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (busy_m !== 1'b0 || done_m !== 1'b0) begin
      errors++;
      $display("FAIL held_start_stop: busy=%b done=%b exp 0 0", busy_m, done_m);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int ndone;
    gt_m = 4'b0000;
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (vec_m !== 2'd2 || fm_m !== 4'b0010) begin
      errors++;
      $display("FAIL pre_abort: vec=%0d fm=%b exp 2 0010", vec_m, fm_m);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({a_m, b_m, busy_m, done_m, fm_m, vec_m} !== 10'd0) begin
      errors++;
      $display("FAIL async_abort: got %b exp 0", {a_m, b_m, busy_m, done_m, fm_m, vec_m});
    end
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_m) ndone++;
    end
    rst = 1'b0;
    repeat (16) begin
      @(posedge clk); #1;
      if (done_m) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d exp 0", ndone);
    end
    run_sweep(1'b0, T_OR, 1'b0);
  endtask

  task automatic test_settle5();
    run_sweep(1'b1, T_OR, 1'b1);
    run_sweep(1'b1, 4'($urandom), 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_sweep(1'b0, 4'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    start_m = 1'b0; start_5 = 1'b0;
    gt_m = T_OR; gt_5 = T_OR;
    glitch_m = 1'b0; glitch_5 = 1'b0; gv_m = 1'b0; gv_5 = 1'b0;
    test_reset();
    test_or_and();
    test_stuck_then_good();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_sweep();
    test_settle5();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
